// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Frame constants and FSM state encoding shared by the UART
//                transmit scheduler and the matching 9-bit receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GUARD  = 3'd5
    } uart_state_t;

    localparam int   DATA_BITS   = 8;
    localparam int   FRAME_BITS  = 11;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Round-robin picker; search starts at an internal pointer that
//                moves past the winner whenever a grant is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_j;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!w_found && req[w_j]) begin
                w_found       = 1'b1;
                grant_idx     = IDX_W'(w_j);
                grant_oh[w_j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART TX line among NUM_REQ requesters; frames are
//                start, 8 data LSB first, parity, stop, optional guard bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int GUARD_BITS   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_BITS-1:0] data_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       tx_out
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    uart_state_t           r_state, w_state_nxt;
    logic [BAUD_W-1:0]     r_baud, w_baud_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt;
    logic [1:0]            r_guard, w_guard_nxt;
    logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic                  r_parity, w_parity_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic [NUM_REQ-1:0]    r_owner, w_owner_nxt;

    logic                  w_start;
    logic                  w_tick;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic [IDX_W-1:0]      w_win_idx;
    logic [DATA_BITS-1:0]  w_win_byte;

    assign w_start    = (r_state == IDLE) && (|req);
    assign w_tick     = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_win_byte = data_in[{w_win_idx, 3'b000} +: DATA_BITS];

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (w_start),
        .grant_oh  (w_win_oh),
        .grant_idx (w_win_idx)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = w_tick ? '0 : r_baud + 1'b1;
        w_bit_nxt    = r_bit;
        w_guard_nxt  = r_guard;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_owner_nxt  = r_owner;
        w_gnt_nxt    = '0;
        w_done_nxt   = '0;
        w_tx_nxt     = r_tx;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (w_start) begin
                    w_state_nxt  = START;
                    w_gnt_nxt    = w_win_oh;
                    w_owner_nxt  = w_win_oh;
                    w_shift_nxt  = w_win_byte;
                    w_parity_nxt = parity_bit(w_win_byte, PARITY_ODD);
                    w_tx_nxt     = START_LEVEL;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = STOP_LEVEL;
                end
            end
            STOP: begin
                // done marks the end of the stop bit, independent of any guard time
                if (w_tick) begin
                    w_done_nxt  = r_owner;
                    w_tx_nxt    = IDLE_LEVEL;
                    w_guard_nxt = '0;
                    w_state_nxt = (GUARD_BITS > 0) ? GUARD : IDLE;
                end
            end
            GUARD: begin
                if (w_tick) begin
                    if (int'(r_guard) == GUARD_BITS - 1) w_state_nxt = IDLE;
                    else                                  w_guard_nxt = r_guard + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = IDLE_LEVEL;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_guard  <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_owner  <= '0;
        end else begin
            r_baud   <= w_baud_nxt;
            r_bit    <= w_bit_nxt;
            r_guard  <= w_guard_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign busy   = r_busy;
    assign tx_out = r_tx;

endmodule
`default_nettype wire
